// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- 64 x 32-bit general-purpose register file for the multi-cycle
// processor datapath. Two combinational read ports, one synchronous write
// port; register 0 reads as zero and ignores writes.
//
// Ports
//   clk       in   1       clock, writes on rising edge
//   rst_n     in   1       asynchronous active-low reset, clears all registers
//   rs1       in   ADDR_W  read address, port 1
//   rs2       in   ADDR_W  read address, port 2
//   rd        in   ADDR_W  write address
//   regwrite  in   1       write enable, sampled at posedge clk
//   wd3       in   DATA_W  write data
//   rd1       out  DATA_W  read data, port 1 (combinational)
//   rd2       out  DATA_W  read data, port 2 (combinational)
//
// Configuration
//   REG_FILE_BYPASS_EN  when defined, a pending write to rd is forwarded
//                       combinationally to any read port addressing rd.
//                       Undefined (default): reads show stored contents only.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              regwrite,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  // Storage array; kept under this name so benches can inspect it directly.
  logic [DATA_W-1:0] regout [0:NUM_REGS-1];

  logic write_ok;

  // A write is only effective out of reset and to a non-zero register.
  assign write_ok = rst_n && regwrite && (rd != '0);

  // Storage update: async clear, otherwise single write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regout[i] <= '0;
      end
    end else if (regwrite && (rd != '0)) begin
      regout[rd] <= wd3;
    end
  end

  // Read ports: register 0 forced to zero, outputs held at zero during reset.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) begin
      rd1 = regout[rs1];
    end
    if (rs2 != '0) begin
      rd2 = regout[rs2];
    end
`ifdef REG_FILE_BYPASS_EN
    // Write-through: the value being written this cycle wins over storage.
    if (write_ok && (rs1 == rd)) begin
      rd1 = wd3;
    end
    if (write_ok && (rs2 == rd)) begin
      rd2 = wd3;
    end
`endif
    if (!rst_n) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

`ifndef REG_FILE_BYPASS_EN
  // write_ok only feeds the forwarding path; keep it referenced here.
  logic unused_write_ok;
  assign unused_write_ok = write_ok;
`endif

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- directed self-checking bench for reg_file.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic [5:0]  rs1;
  logic [5:0]  rs2;
  logic [5:0]  rd;
  logic        regwrite;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks;
  int failures;

  reg_file uut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .regwrite (regwrite),
    .wd3      (wd3),
    .rd1      (rd1),
    .rd2      (rd2)
  );

  // Gated clock so reset can be exercised with the clock idle.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pattern(input int i);
    return 32'(i) * 32'h9E37_79B1 ^ 32'h5A00_00A5;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    rst_n    = 1'b1;
    rs1      = 6'd6;
    rs2      = 6'd10;
    rd       = 6'd0;
    regwrite = 1'b0;
    wd3      = '0;

    // 1. Reset pulse with clock idle.
    #3 rst_n = 1'b0;
    #2;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    #4 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("reset_regout%0d", i), uut.regout[i], 32'h0);
    end
    clk_en = 1'b1;

    // 2. Basic write.
    rd = 6'd20; wd3 = 32'h1234_5678; regwrite = 1'b1;
    tick();
    regwrite = 1'b0;
    check("write_regout20", uut.regout[20], 32'h1234_5678);
    rs1 = 6'd20;
    #1;
    check("write_rd1", rd1, 32'h1234_5678);

    // 3. Write disabled for several edges.
    rd = 6'd18; wd3 = 32'h8765_4321; regwrite = 1'b0; rs2 = 6'd18;
    repeat (3) tick();
    check("disable_regout18", uut.regout[18], 32'h0);
    check("disable_regout20", uut.regout[20], 32'h1234_5678);
    check("disable_rd2", rd2, 32'h0);

    // 4. Re-enable; previous write must survive.
    regwrite = 1'b1;
    tick();
    regwrite = 1'b0;
    check("reenable_rd2", rd2, 32'h8765_4321);
    check("reenable_rd1", rd1, 32'h1234_5678);

    // 5. Register 0 ignores writes, and is never forwarded.
    rd = 6'd0; wd3 = 32'hFFFF_FFFF; regwrite = 1'b1; rs1 = 6'd0;
    #1;
    check("zero_pre_edge_rd1", rd1, 32'h0);
    tick();
    regwrite = 1'b0;
    check("zero_rd1", rd1, 32'h0);
    check("zero_regout0", uut.regout[0], 32'h0);

    // 6. Same-address read during write.
    rs1 = 6'd5; rd = 6'd5; wd3 = 32'hA5A5_A5A5; regwrite = 1'b1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("bypass_pre_edge_rd1", rd1, 32'hA5A5_A5A5);
`else
    check("bypass_pre_edge_rd1", rd1, 32'h0);
`endif
    tick();
    regwrite = 1'b0;
    check("bypass_post_edge_rd1", rd1, 32'hA5A5_A5A5);

    // Held enable rewrites each edge; data/address changes take effect next edge.
    rd = 6'd33; wd3 = 32'h0000_0001; regwrite = 1'b1; rs1 = 6'd33; rs2 = 6'd34;
    tick();
    check("hold_first_rd1", rd1, 32'h0000_0001);
    wd3 = 32'h0000_0002;
    tick();
    check("hold_second_rd1", rd1, 32'h0000_0002);
    rd = 6'd34; wd3 = 32'h0000_0003;
    tick();
    regwrite = 1'b0;
    check("hold_move_rd1", rd1, 32'h0000_0002);
    check("hold_move_rd2", rd2, 32'h0000_0003);

    // Same address on both ports.
    rs1 = 6'd20; rs2 = 6'd20;
    #1;
    check("same_addr_rd1", rd1, 32'h1234_5678);
    check("same_addr_rd2", rd2, 32'h1234_5678);

    // Fill every register, then read back through both ports (incl. 63).
    regwrite = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rd = 6'(i); wd3 = pattern(i);
      tick();
    end
    regwrite = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rs1 = 6'(i); rs2 = 6'(63 - i);
      #1;
      check($sformatf("fill_rd1_%0d", i), rd1, (i == 0) ? 32'h0 : pattern(i));
      check($sformatf("fill_rd2_%0d", i), rd2, (i == 63) ? 32'h0 : pattern(63 - i));
    end

    // Reset mid-run with a write pending: write blocked, contents lost.
    rs1 = 6'd20; rs2 = 6'd63; rd = 6'd7; wd3 = 32'hDEAD_BEEF; regwrite = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_rd1", rd1, 32'h0);
    check("midreset_rd2", rd2, 32'h0);
    tick();
    check("midreset_regout7", uut.regout[7], 32'h0);
    regwrite = 1'b0;
    rst_n = 1'b1;
    #1;
    check("postreset_rd1", rd1, 32'h0);
    check("postreset_regout63", uut.regout[63], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
